// File: rtl/esp_dma_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : esp_dma_read_arbiter
// Description : Shares one ESP DMA read port (ctrl + chnl) between NREQ
//               requesters. Round-robin grant per transaction. The grant is
//               held until every beat of the granted request has returned
//               on the data channel.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk                       in   1        clock
//   rst_n                     in   1        asynchronous reset, active low
//   req_ctrl_valid_i          in   NREQ     per-requester read request valid
//   req_ctrl_index_i          in   NREQ*LW  per-requester index  [r*LW +: LW]
//   req_ctrl_length_i         in   NREQ*LW  per-requester length in beats
//   req_ctrl_size_i           in   NREQ*3   per-requester beat size code
//   req_ctrl_ready_o          out  NREQ     request accepted (one-hot or zero)
//   req_chnl_valid_o          out  NREQ     data beat valid, owner bit only
//   req_chnl_data_o           out  DW       data, broadcast to all requesters
//   req_chnl_ready_i          in   NREQ     per-requester data ready
//   dma_read_ctrl_valid       out  1        request valid to DMA
//   dma_read_ctrl_data_index  out  LW       request index to DMA
//   dma_read_ctrl_data_length out  LW       request length to DMA
//   dma_read_ctrl_data_size   out  3        request size to DMA
//   dma_read_ctrl_ready       in   1        request ready from DMA
//   dma_read_chnl_valid       in   1        data valid from DMA
//   dma_read_chnl_data        in   DW       data from DMA
//   dma_read_chnl_ready       out  1        data ready to DMA
//   owner_o                   out  clog2    current / last owner index
//   busy_o                    out  1        a transaction is in progress
// ============================================================================
module esp_dma_read_arbiter #(
    parameter int NREQ = 2,
    parameter int DW   = 64,
    parameter int LW   = 32
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NREQ-1:0]                      req_ctrl_valid_i,
    input  logic [NREQ*LW-1:0]                   req_ctrl_index_i,
    input  logic [NREQ*LW-1:0]                   req_ctrl_length_i,
    input  logic [NREQ*3-1:0]                    req_ctrl_size_i,
    output logic [NREQ-1:0]                      req_ctrl_ready_o,
    output logic [NREQ-1:0]                      req_chnl_valid_o,
    output logic [DW-1:0]                        req_chnl_data_o,
    input  logic [NREQ-1:0]                      req_chnl_ready_i,
    output logic                                 dma_read_ctrl_valid,
    output logic [LW-1:0]                        dma_read_ctrl_data_index,
    output logic [LW-1:0]                        dma_read_ctrl_data_length,
    output logic [2:0]                           dma_read_ctrl_data_size,
    input  logic                                 dma_read_ctrl_ready,
    input  logic                                 dma_read_chnl_valid,
    input  logic [DW-1:0]                        dma_read_chnl_data,
    output logic                                 dma_read_chnl_ready,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] owner_o,
    output logic                                 busy_o
);

    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CTRL = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [OW-1:0]   r_owner;
    logic [OW-1:0]   w_owner_nxt;
    logic [OW-1:0]   r_rr_ptr;
    logic [OW-1:0]   w_rr_nxt;
    logic [LW-1:0]   r_len;
    logic [LW-1:0]   w_len_nxt;
    logic [LW-1:0]   r_beat_cnt;
    logic [LW-1:0]   w_cnt_nxt;

    logic [OW-1:0]   w_pick;
    logic            w_any_req;
    int              w_slot;
    logic [OW-1:0]   w_owner_inc;
    logic [LW-1:0]   w_own_index;
    logic [LW-1:0]   w_own_length;
    logic [2:0]      w_own_size;
    logic            w_own_valid;
    logic            w_beat;

    // Fields of the currently latched owner
    assign w_own_index  = req_ctrl_index_i[r_owner*LW +: LW];
    assign w_own_length = req_ctrl_length_i[r_owner*LW +: LW];
    assign w_own_size   = req_ctrl_size_i[r_owner*3 +: 3];
    assign w_own_valid  = req_ctrl_valid_i[r_owner];

    // Owner + 1 modulo NREQ (NREQ need not be a power of two)
    assign w_owner_inc = (r_owner == OW'(NREQ - 1)) ? '0 : r_owner + OW'(1);

    // Round-robin search: scan from the highest distance down so the
    // requester closest to rr_ptr (upward, wrapping) is the last to win.
    always_comb begin
        w_pick    = r_rr_ptr;
        w_any_req = 1'b0;
        w_slot    = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_slot = int'(r_rr_ptr) + k;
            if (w_slot >= NREQ) begin
                w_slot = w_slot - NREQ;
            end
            if (req_ctrl_valid_i[OW'(w_slot)]) begin
                w_pick    = OW'(w_slot);
                w_any_req = 1'b1;
            end
        end
    end

    assign w_beat = dma_read_chnl_valid && req_chnl_ready_i[r_owner];

    // Next state, next datapath values and all port outputs
    always_comb begin
        w_state_nxt               = r_state;
        w_owner_nxt               = r_owner;
        w_rr_nxt                  = r_rr_ptr;
        w_len_nxt                 = r_len;
        w_cnt_nxt                 = r_beat_cnt;
        dma_read_ctrl_valid       = 1'b0;
        dma_read_ctrl_data_index  = '0;
        dma_read_ctrl_data_length = '0;
        dma_read_ctrl_data_size   = '0;
        req_ctrl_ready_o          = '0;
        req_chnl_valid_o          = '0;
        req_chnl_data_o           = '0;
        dma_read_chnl_ready       = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Grant takes effect next cycle; nothing is forwarded now
                if (w_any_req) begin
                    w_owner_nxt = w_pick;
                    w_state_nxt = S_CTRL;
                end
            end

            S_CTRL: begin
                dma_read_ctrl_valid       = w_own_valid;
                dma_read_ctrl_data_index  = w_own_index;
                dma_read_ctrl_data_length = w_own_length;
                dma_read_ctrl_data_size   = w_own_size;
                req_ctrl_ready_o[r_owner] = dma_read_ctrl_ready;
                if (!w_own_valid) begin
                    // Owner withdrew: give up without advancing the pointer
                    w_state_nxt = S_IDLE;
                end else if (dma_read_ctrl_ready) begin
                    w_len_nxt = w_own_length;
                    w_cnt_nxt = '0;
                    if (w_own_length == '0) begin
                        w_state_nxt = S_IDLE;
                        w_rr_nxt    = w_owner_inc;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end
            end

            S_DATA: begin
                req_chnl_valid_o[r_owner] = dma_read_chnl_valid;
                req_chnl_data_o           = dma_read_chnl_data;
                dma_read_chnl_ready       = req_chnl_ready_i[r_owner];
                if (w_beat) begin
                    w_cnt_nxt = r_beat_cnt + LW'(1);
                    if (r_beat_cnt == r_len - LW'(1)) begin
                        w_state_nxt = S_IDLE;
                        w_rr_nxt    = w_owner_inc;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_len      <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_len      <= w_len_nxt;
            r_beat_cnt <= w_cnt_nxt;
        end
    end

    assign owner_o = r_owner;
    assign busy_o  = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_esp_dma_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_esp_dma_read_arbiter
// Description : Directed self-checking bench for esp_dma_read_arbiter.
//               Expected data beats are queued when driven and popped when
//               the arbiter hands them to the owning requester.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_esp_dma_read_arbiter;

    localparam int NREQ = 2;
    localparam int DW   = 64;
    localparam int LW   = 32;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_ctrl_valid_i;
    logic [NREQ*LW-1:0]   req_ctrl_index_i;
    logic [NREQ*LW-1:0]   req_ctrl_length_i;
    logic [NREQ*3-1:0]    req_ctrl_size_i;
    logic [NREQ-1:0]      req_ctrl_ready_o;
    logic [NREQ-1:0]      req_chnl_valid_o;
    logic [DW-1:0]        req_chnl_data_o;
    logic [NREQ-1:0]      req_chnl_ready_i;
    logic                 dma_read_ctrl_valid;
    logic [LW-1:0]        dma_read_ctrl_data_index;
    logic [LW-1:0]        dma_read_ctrl_data_length;
    logic [2:0]           dma_read_ctrl_data_size;
    logic                 dma_read_ctrl_ready;
    logic                 dma_read_chnl_valid;
    logic [DW-1:0]        dma_read_chnl_data;
    logic                 dma_read_chnl_ready;
    logic [0:0]           owner_o;
    logic                 busy_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] exp_q[$];

    esp_dma_read_arbiter #(.NREQ(NREQ), .DW(DW), .LW(LW)) dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .req_ctrl_valid_i          (req_ctrl_valid_i),
        .req_ctrl_index_i          (req_ctrl_index_i),
        .req_ctrl_length_i         (req_ctrl_length_i),
        .req_ctrl_size_i           (req_ctrl_size_i),
        .req_ctrl_ready_o          (req_ctrl_ready_o),
        .req_chnl_valid_o          (req_chnl_valid_o),
        .req_chnl_data_o           (req_chnl_data_o),
        .req_chnl_ready_i          (req_chnl_ready_i),
        .dma_read_ctrl_valid       (dma_read_ctrl_valid),
        .dma_read_ctrl_data_index  (dma_read_ctrl_data_index),
        .dma_read_ctrl_data_length (dma_read_ctrl_data_length),
        .dma_read_ctrl_data_size   (dma_read_ctrl_data_size),
        .dma_read_ctrl_ready       (dma_read_ctrl_ready),
        .dma_read_chnl_valid       (dma_read_chnl_valid),
        .dma_read_chnl_data        (dma_read_chnl_data),
        .dma_read_chnl_ready       (dma_read_chnl_ready),
        .owner_o                   (owner_o),
        .busy_o                    (busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=time-limit expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int r, input logic [LW-1:0] idx, input logic [LW-1:0] len,
                           input logic [2:0] sz);
        req_ctrl_valid_i[r]          = 1'b1;
        req_ctrl_index_i[r*LW +: LW] = idx;
        req_ctrl_length_i[r*LW +: LW] = len;
        req_ctrl_size_i[r*3 +: 3]    = sz;
    endtask

    // Every output must be zero (owner_o holds exp_own)
    task automatic check_quiet(input string tag, input int exp_own);
        #1;
        chk({tag, ".ctrl_valid"},  dma_read_ctrl_valid, 0);
        chk({tag, ".ctrl_index"},  dma_read_ctrl_data_index, 0);
        chk({tag, ".ctrl_length"}, dma_read_ctrl_data_length, 0);
        chk({tag, ".ctrl_size"},   dma_read_ctrl_data_size, 0);
        chk({tag, ".req_ready"},   req_ctrl_ready_o, 0);
        chk({tag, ".chnl_valid"},  req_chnl_valid_o, 0);
        chk({tag, ".chnl_data"},   req_chnl_data_o, 0);
        chk({tag, ".chnl_ready"},  dma_read_chnl_ready, 0);
        chk({tag, ".busy"},        busy_o, 0);
        chk({tag, ".owner"},       owner_o, exp_own);
    endtask

    // Called in the cycle the request(s) are visible to an idle arbiter.
    task automatic grant(input int own, input logic [LW-1:0] idx, input logic [LW-1:0] len,
                         input logic [2:0] sz, input string tag);
        logic [NREQ-1:0] oh;
        oh      = '0;
        oh[own] = 1'b1;
        #1;
        chk({tag, ".arb_no_ctrl"}, dma_read_ctrl_valid, 0);
        chk({tag, ".arb_busy"},    busy_o, 0);
        @(negedge clk); #1;
        chk({tag, ".ctrl_valid"},  dma_read_ctrl_valid, 1);
        chk({tag, ".ctrl_index"},  dma_read_ctrl_data_index, idx);
        chk({tag, ".ctrl_length"}, dma_read_ctrl_data_length, len);
        chk({tag, ".ctrl_size"},   dma_read_ctrl_data_size, sz);
        chk({tag, ".owner"},       owner_o, own);
        chk({tag, ".busy"},        busy_o, 1);
        chk({tag, ".ready_wait"},  req_ctrl_ready_o, 0);
        dma_read_ctrl_ready = 1'b1;
        #1;
        chk({tag, ".ready_onehot"}, req_ctrl_ready_o, oh);
        @(negedge clk);
        dma_read_ctrl_ready  = 1'b0;
        req_ctrl_valid_i[own] = 1'b0;
        #1;
        chk({tag, ".ctrl_dropped"}, dma_read_ctrl_valid, 0);
    endtask

    // Feeds n beats; ready toggles 1/0 when toggle is set. abort_at >= 0
    // pulses reset while that beat is being presented.
    task automatic data_phase(input int own, input int n, input bit toggle, input int abort_at,
                              input logic [DW-1:0] base, input string tag);
        int              cnt;
        int              cyc;
        bit              pending;
        logic [DW-1:0]   d;
        logic [DW-1:0]   e;
        logic            rdy;
        logic [NREQ-1:0] ov;
        cnt     = 0;
        cyc     = 0;
        pending = 1'b0;
        d       = '0;
        ov      = '0;
        ov[own] = 1'b1;
        while (cnt < n && cyc < 200) begin
            if (!pending) begin
                d = base + DW'(cnt);
                exp_q.push_back(d);
                pending = 1'b1;
            end
            rdy = toggle ? ~cyc[0] : 1'b1;
            dma_read_chnl_valid = 1'b1;
            dma_read_chnl_data  = d;
            // Non-owners always claim ready; the arbiter must ignore them
            req_chnl_ready_i    = ~ov | (rdy ? ov : '0);
            #1;
            chk({tag, ".busy"},       busy_o, 1);
            chk({tag, ".chnl_valid"}, req_chnl_valid_o, ov);
            chk({tag, ".chnl_ready"}, dma_read_chnl_ready, rdy);
            chk({tag, ".no_ctrl_rdy"}, req_ctrl_ready_o, 0);
            chk({tag, ".no_ctrl_vld"}, dma_read_ctrl_valid, 0);
            if (abort_at == cnt) begin
                rst_n = 1'b0;
                check_quiet({tag, ".async_rst"}, 0);
                exp_q.delete();
                dma_read_chnl_valid = 1'b0;
                req_chnl_ready_i    = '0;
                return;
            end
            if (rdy) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                chk({tag, ".data"}, req_chnl_data_o, e);
                pending = 1'b0;
                cnt++;
            end
            cyc++;
            @(negedge clk);
        end
        chk({tag, ".beats_done"}, cnt, n);
        // A stray DMA beat in IDLE must be stalled and not routed
        #1;
        chk({tag, ".stray_ready"}, dma_read_chnl_ready, 0);
        chk({tag, ".stray_valid"}, req_chnl_valid_o, 0);
        chk({tag, ".end_busy"},    busy_o, 0);
        dma_read_chnl_valid = 1'b0;
        req_chnl_ready_i    = '0;
    endtask

    initial begin
        rst_n               = 1'b0;
        req_ctrl_valid_i    = '0;
        req_ctrl_index_i    = '0;
        req_ctrl_length_i   = '0;
        req_ctrl_size_i     = '0;
        req_chnl_ready_i    = '0;
        dma_read_ctrl_ready = 1'b0;
        dma_read_chnl_valid = 1'b0;
        dma_read_chnl_data  = '0;

        // Reset: outputs stay zero even with a request pending
        repeat (2) @(negedge clk);
        set_req(0, 32'h0000_0123, 32'd5, 3'd3);
        check_quiet("reset", 0);
        @(negedge clk);
        req_ctrl_valid_i = '0;
        rst_n = 1'b1;
        check_quiet("post_reset", 0);

        // 1: single request r0, idx 0x100 len 4 size 3
        @(negedge clk);
        set_req(0, 32'h100, 32'd4, 3'd3);
        grant(0, 32'h100, 32'd4, 3'd3, "t1");
        data_phase(0, 4, 1'b0, -1, 64'hA000, "t1");
        check_quiet("t1.idle", 0);

        // 4: zero-length from r1 (rr_ptr is 1 here, wraps to 0 afterwards)
        set_req(1, 32'h200, 32'd0, 3'd2);
        grant(1, 32'h200, 32'd0, 3'd2, "t4");
        check_quiet("t4.idle", 1);

        // 2: simultaneous requests with rr_ptr=0 -> r0 then r1
        set_req(0, 32'h300, 32'd2, 3'd3);
        set_req(1, 32'h400, 32'd3, 3'd3);
        grant(0, 32'h300, 32'd2, 3'd3, "t2a");
        data_phase(0, 2, 1'b0, -1, 64'hB000, "t2a");
        grant(1, 32'h400, 32'd3, 3'd3, "t2b");
        data_phase(1, 3, 1'b0, -1, 64'hB100, "t2b");
        // pointer wrapped to 0: r0 wins again
        set_req(0, 32'h310, 32'd1, 3'd1);
        set_req(1, 32'h410, 32'd1, 3'd1);
        grant(0, 32'h310, 32'd1, 3'd1, "t2c");
        data_phase(0, 1, 1'b0, -1, 64'hB200, "t2c");
        req_ctrl_valid_i[1] = 1'b0;
        check_quiet("t2c.idle", 0);

        // 3: backpressure, 8 beats with toggling owner ready
        @(negedge clk);
        set_req(0, 32'h500, 32'd8, 3'd3);
        grant(0, 32'h500, 32'd8, 3'd3, "t3");
        data_phase(0, 8, 1'b1, -1, 64'hC000, "t3");

        // 5: r1 requests during r0's 16-beat DATA phase and must wait
        set_req(0, 32'h600, 32'd16, 3'd3);
        grant(0, 32'h600, 32'd16, 3'd3, "t5a");
        set_req(1, 32'h700, 32'd1, 3'd3);
        dma_read_ctrl_ready = 1'b1;
        data_phase(0, 16, 1'b0, -1, 64'hD000, "t5a");
        dma_read_ctrl_ready = 1'b0;
        grant(1, 32'h700, 32'd1, 3'd3, "t5b");
        data_phase(1, 1, 1'b0, -1, 64'hD100, "t5b");

        // 6: reset during beat 3 of 8, then a fresh r1 request
        set_req(0, 32'h800, 32'd8, 3'd3);
        grant(0, 32'h800, 32'd8, 3'd3, "t6a");
        data_phase(0, 8, 1'b0, 2, 64'hE000, "t6a");
        @(negedge clk);
        req_ctrl_valid_i = '0;
        rst_n = 1'b1;
        check_quiet("t6.released", 0);
        set_req(1, 32'h900, 32'd2, 3'd3);
        grant(1, 32'h900, 32'd2, 3'd3, "t6b");
        data_phase(1, 2, 1'b0, -1, 64'hF000, "t6b");
        check_quiet("t6.idle", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
